// File: rtl/x_delay_line_capture.sv
// Delay-line capture front end: launch, double-register taps, thermometer encode, hold until ack.
// Optional majority bubble filter enabled by defining X_CAPTURE_BUBBLE_FIX_EN.
module x_delay_line_capture #(
   parameter int unsigned P_LENGTH = 32,
   parameter int unsigned P_CLEAR  = 8
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_arm,
   input  logic                            i_ack,
   input  logic [P_LENGTH-1:0]             i_taps,
   output logic                            o_launch,
   output logic [P_LENGTH-1:0]             o_data,
   output logic [$clog2(P_LENGTH+1)-1:0]   o_edge_pos,
   output logic                            o_ovf,
   output logic                            o_valid,
   output logic                            o_busy
);

   localparam int unsigned EW = $clog2(P_LENGTH + 1);
   localparam int unsigned CW = $clog2(P_CLEAR + 1);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      SAMPLE,
      SYNC,
      HOLD,
      CLEAR
   } state_t;

   state_t              state, state_d;
   logic [CW-1:0]       cnt, cnt_d;
   logic                launch_d, valid_d;
   logic [P_LENGTH-1:0] cap1, cap2, code;
   logic [EW-1:0]       pos;
   logic                run;

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      launch_d = 1'b0;
      valid_d  = o_valid;
      unique case (state)
         IDLE: begin
            if (i_arm) begin
               state_d  = LAUNCH;
               launch_d = 1'b1;
            end
         end
         LAUNCH: state_d = SAMPLE;
         SAMPLE: state_d = SYNC;
         SYNC: begin
            state_d = HOLD;
            valid_d = 1'b1;
         end
         HOLD: begin
            if (i_ack) begin
               state_d = CLEAR;
               valid_d = 1'b0;
               cnt_d   = CW'(P_CLEAR - 1);
            end
         end
         CLEAR: begin
            if (cnt == '0) state_d = IDLE;
            else           cnt_d   = cnt - CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef X_CAPTURE_BUBBLE_FIX_EN
   // ext[i+1] is cap2[i]; ends padded so the line reads as ones below tap 0 and zeros past the top.
   logic [P_LENGTH+1:0] ext;
   assign ext = {1'b0, cap2, 1'b1};

   always_comb begin
      code = '0;
      for (int unsigned i = 0; i < P_LENGTH; i++) begin
         code[i] = (ext[i] & ext[i+1]) | (ext[i+1] & ext[i+2]) | (ext[i] & ext[i+2]);
      end
   end
`else
   assign code = cap2;
`endif

   // Leading-ones count from tap 0; anything above the first zero is ignored.
   always_comb begin
      pos = '0;
      run = 1'b1;
      for (int unsigned i = 0; i < P_LENGTH; i++) begin
         if (run && code[i]) pos = EW'(i + 1);
         else                run = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         cnt        <= '0;
         cap1       <= '0;
         cap2       <= '0;
         o_launch   <= 1'b0;
         o_valid    <= 1'b0;
         o_data     <= '0;
         o_edge_pos <= '0;
         o_ovf      <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         o_launch <= launch_d;
         o_valid  <= valid_d;
         if (state == LAUNCH) cap1 <= i_taps;
         if (state == SAMPLE) cap2 <= cap1;
         if (state == SYNC) begin
            o_data     <= cap2;
            o_edge_pos <= pos;
            o_ovf      <= &code;
         end
      end
   end

   assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_x_delay_line_capture.sv
// Self-checking bench for x_delay_line_capture: vector table, corner sequences, random captures.
// Reference model follows X_CAPTURE_BUBBLE_FIX_EN the same way the design does.
module tb_x_delay_line_capture;

   localparam int unsigned L  = 32;
   localparam int unsigned PC = 8;
   localparam int unsigned EW = $clog2(L + 1);

   logic          i_clk = 1'b0;
   logic          i_rst, i_arm, i_ack;
   logic [L-1:0]  i_taps;
   logic          o_launch, o_ovf, o_valid, o_busy;
   logic [L-1:0]  o_data;
   logic [EW-1:0] o_edge_pos;

   int unsigned checks = 0;
   int unsigned errors = 0;

   x_delay_line_capture #(.P_LENGTH(L), .P_CLEAR(PC)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_arm      (i_arm),
      .i_ack      (i_ack),
      .i_taps     (i_taps),
      .o_launch   (o_launch),
      .o_data     (o_data),
      .o_edge_pos (o_edge_pos),
      .o_ovf      (o_ovf),
      .o_valid    (o_valid),
      .o_busy     (o_busy)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Lowest zero isolated arithmetically; its log2 is the edge position.
   function automatic int unsigned model_pos(input logic [L-1:0] t);
      logic [L-1:0] c, lowz;
      c = t;
`ifdef X_CAPTURE_BUBBLE_FIX_EN
      begin
         logic [L-1:0] lo, hi;
         lo = (c << 1) | 1;
         hi = c >> 1;
         c  = (lo & c) | (c & hi) | (lo & hi);
      end
`endif
      lowz = ~c & (c + 1);
      if (lowz == '0) return L;
      return $clog2(lowz);
   endfunction

   task automatic do_capture(input logic [L-1:0] t, input int unsigned ep, input logic eo);
      i_taps = t;
      i_arm  = 1'b1;
      step();
      chk("launch_hi", o_launch, 1);
      chk("busy_hi", o_busy, 1);
      i_arm = 1'b0;
      step();
      chk("launch_lo", o_launch, 0);
      step();
      chk("valid_early", o_valid, 0);
      step();
      chk("valid", o_valid, 1);
      chk("data", o_data, t);
      chk("edge_pos", o_edge_pos, ep);
      chk("ovf", o_ovf, eo);
   endtask

   task automatic do_ack(input logic [L-1:0] t);
      i_ack = 1'b1;
      step();
      i_ack = 1'b0;
      chk("ack_valid_lo", o_valid, 0);
      chk("ack_data_kept", o_data, t);
      chk("clear_busy", o_busy, 1);
      repeat (PC - 1) begin
         step();
         chk("clear_busy", o_busy, 1);
      end
      step();
      chk("clear_done", o_busy, 0);
   endtask

   typedef struct {
      logic [L-1:0] taps;
      int unsigned  pos;
      logic         ovf;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{32'h0000_00FF, 8, 1'b0};
      vecs[1] = '{32'hFFFF_FFFF, 32, 1'b1};
      vecs[2] = '{32'h0000_0000, 0, 1'b0};
`ifdef X_CAPTURE_BUBBLE_FIX_EN
      vecs[3] = '{32'h0000_0F7F, 12, 1'b0};
`else
      vecs[3] = '{32'h0000_0F7F, 7, 1'b0};
`endif
      vecs[4] = '{32'h0000_0001, 1, 1'b0};
      vecs[5] = '{32'h7FFF_FFFF, 31, 1'b0};
      vecs[6] = '{32'h0000_0003, 2, 1'b0};
      vecs[7] = '{32'h0000_FFFF, 16, 1'b0};

      i_rst = 1'b1; i_arm = 1'b0; i_ack = 1'b0; i_taps = '1;
      step();
      step();
      chk("rst_launch", o_launch, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_data", o_data, 0);
      chk("rst_pos", o_edge_pos, 0);
      chk("rst_ovf", o_ovf, 0);
      i_rst = 1'b0;
      step();

      foreach (vecs[k]) begin
         do_capture(vecs[k].taps, vecs[k].pos, vecs[k].ovf);
         do_ack(vecs[k].taps);
      end

      // Arm and tap changes in HOLD are ignored; an arm pulse in CLEAR is not queued.
      do_capture(32'h0000_003F, 6, 1'b0);
      i_taps = 32'h1234_5678;
      i_arm  = 1'b1;
      step();
      chk("hold_no_launch", o_launch, 0);
      chk("hold_valid", o_valid, 1);
      chk("hold_data", o_data, 32'h0000_003F);
      chk("hold_pos", o_edge_pos, 6);
      i_arm = 1'b1;
      i_ack = 1'b1;
      step();
      i_arm = 1'b0;
      i_ack = 1'b0;
      chk("arm_ack_valid", o_valid, 0);
      chk("arm_ack_no_launch", o_launch, 0);
      for (int k = 1; k < PC; k++) begin
         i_arm = (k == 3);
         step();
         chk("clr_no_launch", o_launch, 0);
         chk("clr_busy", o_busy, 1);
      end
      i_arm = 1'b0;
      step();
      chk("clr_end", o_busy, 0);
      step();
      chk("no_queued_arm", o_launch, 0);
      chk("no_queued_busy", o_busy, 0);

      // Reset during SAMPLE aborts the capture.
      i_taps = 32'h0000_0FFF;
      i_arm  = 1'b1;
      step();
      i_arm = 1'b0;
      step();
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      chk("abort_launch", o_launch, 0);
      chk("abort_valid", o_valid, 0);
      chk("abort_busy", o_busy, 0);
      chk("abort_data", o_data, 0);
      do_capture(32'h0000_0FFF, 12, 1'b0);
      do_ack(32'h0000_0FFF);

      // Arm held high, ack two cycles after valid: one launch per capture, fixed period.
      begin
         int unsigned cyc = 0, n = 0, last = 0, hold = 0;
         i_taps = 32'h0000_00FF;
         i_arm  = 1'b1;
         while (n < 4 && cyc < 80) begin
            step();
            cyc++;
            if (o_launch) begin
               if (n > 0) chk("arm_period", cyc - last, 4 + 2 + PC);
               last = cyc;
               n++;
            end
            hold  = o_valid ? hold + 1 : 0;
            i_ack = (hold == 2);
         end
         chk("arm_launches", n, 4);
         i_arm = 1'b0;
         for (int k = 0; k < 40; k++) begin
            step();
            if (!o_busy) break;
            i_ack = o_valid;
         end
         i_ack = 1'b0;
         chk("drain_idle", o_busy, 0);
      end

      // Randomised captures against the model.
      for (int r = 0; r < 40; r++) begin
         logic [L-1:0] t;
         logic [L:0]   th;
         int unsigned  ep;
         th = (33'd1 << $urandom_range(0, L)) - 33'd1;
         t  = th[L-1:0];
         if ($urandom_range(0, 3) == 0) t = t ^ (32'd1 << $urandom_range(0, L - 1));
         if ($urandom_range(0, 7) == 0) t = $urandom;
         ep = model_pos(t);
         i_taps = t;
         i_arm  = 1'b1;
         step();
         i_arm = 1'b0;
         for (int k = 0; k < 8; k++) begin
            if (o_valid) break;
            step();
         end
         chk("rnd_valid", o_valid, 1);
         chk("rnd_data", o_data, t);
         chk("rnd_pos", o_edge_pos, ep);
         chk("rnd_ovf", o_ovf, (ep == L));
         repeat ($urandom_range(0, 3)) begin
            i_taps = $urandom;
            i_arm  = $urandom_range(0, 1);
            step();
            chk("rnd_hold_data", o_data, t);
            chk("rnd_hold_launch", o_launch, 0);
         end
         i_arm = 1'b0;
         i_ack = 1'b1;
         step();
         i_ack = 1'b0;
         chk("rnd_ack", o_valid, 0);
         for (int k = 0; k < PC + 2; k++) begin
            if (!o_busy) break;
            step();
         end
         chk("rnd_idle", o_busy, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
